instr_fetch_queue: RTL

- Fetch-side consumer of the program counter.
- Owns the fetch PC, issues word reads to a synchronous-read instruction memory (1-cycle latency) and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- A redirect from branch/jump resolution flushes the buffer and restarts fetch at the new PC.

---
 rtl/instr_fetch_queue.sv | 84 ++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns fetch PC, issues imem reads, buffers {instr,pc} in a FIFO for decode; FETCH_STATS_EN adds stat_fetched/stat_flushed
module instr_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] fetch_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_flushed
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = PW + 2;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic [CW-1:0] credits;
  logic inflight, push, pop;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  assign credits = CW'(count) + CW'(inflight);
  assign imem_req = !RST && !redirect_valid && credits < CW'(DEPTH);
  assign imem_addr = fetch_pc;
  assign instr_valid = count != '0;
  assign instr_data = instr_valid ? data_q[rd_ptr] : '0;
  assign instr_pc = instr_valid ? pc_q[rd_ptr] : '0;
  assign push = !RST && !redirect_valid && inflight;
  assign pop = !RST && !redirect_valid && instr_valid && instr_ready;
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= 1'b0;
    end else begin
      fetch_pc <= imem_req ? fetch_pc + ADDR_WIDTH'(4) : fetch_pc;
      inflight <= imem_req;
      inflight_pc <= imem_req ? fetch_pc : inflight_pc;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + NW'(push) - NW'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr] <= inflight_pc;
    end
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(pop);
      stat_flushed <= stat_flushed + (redirect_valid ? 32'(count) + 32'(inflight) : 32'd0);
    end
  end
`endif
endmodule
